// File: rtl/wifi_link_pkg.sv
// rtl/wifi_link_pkg.sv - shared constants and types for the WiFi link bridge
package wifi_link_pkg;

  localparam logic [7:0] CMD_DISARM = 8'h49;
  localparam logic [7:0] CMD_ARM    = 8'h41;
  localparam logic [7:0] CMD_EMERG  = 8'h45;
  localparam logic [7:0] CMD_ALARM  = 8'h4C;
  localparam logic [7:0] CMD_STATUS = 8'h53;

  localparam logic [3:0] IW_IDLE   = 4'b0000;
  localparam logic [3:0] IW_DISARM = 4'b1010;
  localparam logic [3:0] IW_ARM    = 4'b1011;
  localparam logic [3:0] IW_EMERG  = 4'b1100;
  localparam logic [3:0] IW_ALARM  = 4'b0000;

  localparam logic [2:0] IW2_IDLE   = 3'b000;
  localparam logic [2:0] IW2_DISARM = 3'b010;
  localparam logic [2:0] IW2_ARM    = 3'b001;
  localparam logic [2:0] IW2_EMERG  = 3'b011;
  localparam logic [2:0] IW2_ALARM  = 3'b100;

  localparam logic [1:0] ST_INACTIVE = 2'b11;
  localparam logic [1:0] ST_ACTIVE   = 2'b10;
  localparam logic [1:0] ST_ALARM    = 2'b01;
  localparam logic [1:0] ST_EMERG    = 2'b00;
  localparam logic [7:0] ASCII_BASE  = 8'h30;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} link_state_e;

  // Inverting the active-low status pair maps INACTIVE..EMERGENCY onto '0'..'3'.
  function automatic logic [7:0] status_byte(input logic [1:0] st);
    return ASCII_BASE + {6'b000000, ~st};
  endfunction

endpackage

// File: rtl/uart_rx_8n1.sv
// rtl/uart_rx_8n1.sv - 8N1 receiver with input synchronizer and mid-bit sampling
module uart_rx_8n1 import wifi_link_pkg::*; #(
  parameter int DIV = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] data,
  output logic       frame_err
);

  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] HALF_LAST = CW'(DIV / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(DIV - 1);

  logic          meta_q, meta_d, sync_q, sync_d, prev_q, prev_d;
  link_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          stop_tick;

  always_comb begin
    meta_d  = rx;
    sync_d  = meta_q;
    prev_d  = sync_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    case (state_q)
      S_IDLE: begin
        if (prev_q && !sync_q) begin
          state_d = S_START;
          cnt_d   = '0;
        end
      end
      S_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = sync_q ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          shift_d = {sync_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = S_STOP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_STOP: begin
        if (cnt_q == BIT_LAST) state_d = S_IDLE;
        else                   cnt_d   = cnt_q + CW'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q  <= 1'b1;
      sync_q  <= 1'b1;
      prev_q  <= 1'b1;
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      meta_q  <= meta_d;
      sync_q  <= sync_d;
      prev_q  <= prev_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

  // The stop verdict is presented in the sampling cycle so the consumer can act one edge later.
  assign stop_tick  = (state_q == S_STOP) && (cnt_q == BIT_LAST);
  assign byte_valid = stop_tick && sync_q;
  assign frame_err  = stop_tick && !sync_q;
  assign data       = shift_q;

endmodule

// File: rtl/wifi_link_bridge.sv
// rtl/wifi_link_bridge.sv - UART command decoder and status reporter between WiFi module and alarm FSM
module wifi_link_bridge import wifi_link_pkg::*; #(
  parameter int CLK_HZ       = 50_000_000,
  parameter int BAUD         = 115_200,
  parameter int CMD_HOLD_CYC = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic       tx,
  input  logic       outWIFI,
  input  logic       outWIFI2,
  output logic [3:0] inWIFI,
  output logic [2:0] inWIFI2,
  output logic       link_err
);

  localparam int DIV = CLK_HZ / BAUD;
  localparam int CW  = $clog2(DIV);
  localparam int HW  = $clog2(CMD_HOLD_CYC + 1);
  localparam logic [CW-1:0] BIT_LAST = CW'(DIV - 1);

  logic       rx_valid, rx_ferr;
  logic [7:0] rx_data;

  uart_rx_8n1 #(.DIV(DIV)) u_rx (
    .clk        (clk),
    .rst_n      (reset),
    .rx         (rx),
    .byte_valid (rx_valid),
    .data       (rx_data),
    .frame_err  (rx_ferr)
  );

  logic          cmd_hit, query, unknown;
  logic [3:0]    cmd_iw, iw_q, iw_d;
  logic [2:0]    cmd_iw2, iw2_q, iw2_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          link_err_q, link_err_d;
  logic [1:0]    stat_meta_q, stat_meta_d, stat_sync_q, stat_sync_d, hist_q, hist_d;
  logic          report_req;
  link_state_e   tx_state_q, tx_state_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]    tx_bit_q, tx_bit_d;
  logic [7:0]    tx_shift_q, tx_shift_d;
  logic          tx_q, tx_d, pending_q, pending_d, bit_done, load;

  always_comb begin
    cmd_hit = 1'b0;
    query   = 1'b0;
    unknown = 1'b0;
    cmd_iw  = IW_IDLE;
    cmd_iw2 = IW2_IDLE;
    if (rx_valid) begin
      case (rx_data)
        CMD_DISARM: begin cmd_hit = 1'b1; cmd_iw = IW_DISARM; cmd_iw2 = IW2_DISARM; end
        CMD_ARM:    begin cmd_hit = 1'b1; cmd_iw = IW_ARM;    cmd_iw2 = IW2_ARM;    end
        CMD_EMERG:  begin cmd_hit = 1'b1; cmd_iw = IW_EMERG;  cmd_iw2 = IW2_EMERG;  end
        CMD_ALARM:  begin cmd_hit = 1'b1; cmd_iw = IW_ALARM;  cmd_iw2 = IW2_ALARM;  end
        CMD_STATUS: query   = 1'b1;
        default:    unknown = 1'b1;
      endcase
    end
  end

  // A fresh command reloads the window; otherwise the code clears on the last held cycle.
  always_comb begin
    iw_d   = iw_q;
    iw2_d  = iw2_q;
    hold_d = hold_q;
    if (cmd_hit) begin
      iw_d   = cmd_iw;
      iw2_d  = cmd_iw2;
      hold_d = HW'(CMD_HOLD_CYC);
    end else if (hold_q != '0) begin
      hold_d = hold_q - HW'(1);
      if (hold_q == HW'(1)) begin
        iw_d  = IW_IDLE;
        iw2_d = IW2_IDLE;
      end
    end
    link_err_d = rx_ferr || unknown;
  end

  always_comb begin
    stat_meta_d = {outWIFI, outWIFI2};
    stat_sync_d = stat_meta_q;
    hist_d      = stat_sync_q;
    report_req  = (stat_sync_q != hist_q) || query;
  end

  // Requests arriving while a frame is in flight collapse into one pending flag.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_d       = tx_q;
    pending_d  = pending_q;
    load       = 1'b0;
    bit_done   = (tx_cnt_q == BIT_LAST);
    if (tx_state_q != S_IDLE) tx_cnt_d = bit_done ? '0 : tx_cnt_q + CW'(1);
    case (tx_state_q)
      S_IDLE:  load = report_req || pending_q;
      S_START: begin
        if (bit_done) begin
          tx_state_d = S_DATA;
          tx_bit_d   = '0;
          tx_d       = tx_shift_q[0];
        end
      end
      S_DATA: begin
        if (bit_done) begin
          if (tx_bit_q == 3'd7) begin
            tx_state_d = S_STOP;
            tx_d       = 1'b1;
          end else begin
            tx_bit_d   = tx_bit_q + 3'd1;
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
            tx_d       = tx_shift_q[1];
          end
        end
      end
      S_STOP: begin
        if (bit_done) begin
          if (report_req || pending_q) load = 1'b1;
          else                         tx_state_d = S_IDLE;
        end
      end
      default: tx_state_d = S_IDLE;
    endcase
    if (load) begin
      tx_state_d = S_START;
      tx_cnt_d   = '0;
      tx_shift_d = status_byte(stat_sync_q);
      tx_d       = 1'b0;
      pending_d  = 1'b0;
    end else if (report_req && tx_state_q != S_IDLE) begin
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      iw_q        <= IW_IDLE;
      iw2_q       <= IW2_IDLE;
      hold_q      <= '0;
      link_err_q  <= 1'b0;
      stat_meta_q <= ST_INACTIVE;
      stat_sync_q <= ST_INACTIVE;
      hist_q      <= ST_INACTIVE;
      tx_state_q  <= S_IDLE;
      tx_cnt_q    <= '0;
      tx_bit_q    <= '0;
      tx_shift_q  <= '0;
      tx_q        <= 1'b1;
      pending_q   <= 1'b0;
    end else begin
      iw_q        <= iw_d;
      iw2_q       <= iw2_d;
      hold_q      <= hold_d;
      link_err_q  <= link_err_d;
      stat_meta_q <= stat_meta_d;
      stat_sync_q <= stat_sync_d;
      hist_q      <= hist_d;
      tx_state_q  <= tx_state_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_bit_q    <= tx_bit_d;
      tx_shift_q  <= tx_shift_d;
      tx_q        <= tx_d;
      pending_q   <= pending_d;
    end
  end

  assign tx       = tx_q;
  assign inWIFI   = iw_q;
  assign inWIFI2  = iw2_q;
  assign link_err = link_err_q;

endmodule

// File: tb/tb_wifi_link_bridge.sv
// tb/tb_wifi_link_bridge.sv - self-checking bench for wifi_link_bridge
module tb_wifi_link_bridge;

  localparam int HOLD = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx = 1'b1;
  logic       tx;
  logic       outWIFI = 1'b1;
  logic       outWIFI2 = 1'b1;
  logic [3:0] inWIFI;
  logic [2:0] inWIFI2;
  logic       link_err;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int sc_base = 0;

  logic [7:0] tx_bytes[$];
  logic       tx_ok[$];
  int         tx_t[$];
  logic [7:0] mon_b;
  logic       mon_ok;
  int         mon_t;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  wifi_link_bridge #(.CLK_HZ(16), .BAUD(1), .CMD_HOLD_CYC(HOLD)) dut (
    .clk      (clk),
    .reset    (reset),
    .rx       (rx),
    .tx       (tx),
    .outWIFI  (outWIFI),
    .outWIFI2 (outWIFI2),
    .inWIFI   (inWIFI),
    .inWIFI2  (inWIFI2),
    .link_err (link_err)
  );

  initial begin
    forever begin
      @(negedge tx);
      mon_t = cyc;
      repeat (8) @(negedge clk);
      mon_ok = (tx === 1'b0);
      for (int i = 0; i < 8; i++) begin
        repeat (16) @(negedge clk);
        mon_b[i] = tx;
      end
      repeat (16) @(negedge clk);
      mon_ok = mon_ok && (tx === 1'b1);
      tx_bytes.push_back(mon_b);
      tx_ok.push_back(mon_ok);
      tx_t.push_back(mon_t);
    end
  end

  function automatic void ref_decode(input logic [7:0] b, output logic [6:0] code, output logic err);
    code = 7'd0;
    err  = 1'b0;
    case (b)
      8'h49:   code = 7'b1010_010;
      8'h41:   code = 7'b1011_001;
      8'h45:   code = 7'b1100_011;
      8'h4C:   code = 7'b0000_100;
      8'h53:   code = 7'd0;
      default: err  = 1'b1;
    endcase
  endfunction

  function automatic logic [7:0] ref_report(input int st);
    return 8'(8'h30 + (3 - st));
  endfunction

  task automatic send_frame(input logic [7:0] b, input logic stop);
    @(negedge clk);
    rx = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (16) @(negedge clk);
    end
    rx = stop;
  endtask

  task automatic observe_cmd(input logic [7:0] b, input logic stop, input logic [6:0] exp,
                             output int first, output int cnt, output int other,
                             output int errs, output int txlow);
    send_frame(b, stop);
    first = -1; cnt = 0; other = 0; errs = 0; txlow = 0;
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk);
      if (k == 16) rx = 1'b1;
      if (exp != 7'd0 && {inWIFI, inWIFI2} === exp) begin
        if (first < 0) first = k;
        cnt++;
      end else if ({inWIFI, inWIFI2} !== 7'd0) begin
        other++;
      end
      if (link_err === 1'b1) errs++;
      if (tx !== 1'b1) txlow++;
    end
  endtask

  task automatic test_reset();
    int busy;
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (tx !== 1'b1) begin failures++; $display("FAIL reset_tx got=%b exp=1", tx); end
    checks++; if (inWIFI !== 4'b0000) begin failures++; $display("FAIL reset_inWIFI got=%b exp=0000", inWIFI); end
    checks++; if (inWIFI2 !== 3'b000) begin failures++; $display("FAIL reset_inWIFI2 got=%b exp=000", inWIFI2); end
    checks++; if (link_err !== 1'b0) begin failures++; $display("FAIL reset_link_err got=%b exp=0", link_err); end
    reset = 1'b1;
    busy = 0;
    repeat (40) begin
      @(negedge clk);
      if (tx !== 1'b1 || link_err !== 1'b0 || {inWIFI, inWIFI2} !== 7'd0) busy++;
    end
    checks++; if (busy != 0) begin failures++; $display("FAIL post_reset_quiet got=%0d active cycles exp=0", busy); end
  endtask

  task automatic test_arm();
    int first, cnt, other, errs, txlow;
    observe_cmd(8'h41, 1'b1, 7'b1011_001, first, cnt, other, errs, txlow);
    checks++; if (first < 10 || first > 12) begin failures++; $display("FAIL arm_latency got=%0d exp=10..12", first); end
    checks++; if (cnt != HOLD) begin failures++; $display("FAIL arm_hold got=%0d exp=%0d", cnt, HOLD); end
    checks++; if (other != 0) begin failures++; $display("FAIL arm_other_code got=%0d exp=0", other); end
    checks++; if (errs != 0) begin failures++; $display("FAIL arm_link_err got=%0d exp=0", errs); end
  endtask

  task automatic test_framing_err();
    int first, cnt, other, errs, txlow;
    observe_cmd(8'h49, 1'b0, 7'd0, first, cnt, other, errs, txlow);
    checks++; if (errs != 1) begin failures++; $display("FAIL frame_err_pulse got=%0d exp=1", errs); end
    checks++; if (other != 0) begin failures++; $display("FAIL frame_err_code got=%0d exp=0", other); end
  endtask

  task automatic test_unknown();
    int first, cnt, other, errs, txlow;
    observe_cmd(8'h7A, 1'b1, 7'd0, first, cnt, other, errs, txlow);
    checks++; if (errs != 1) begin failures++; $display("FAIL unknown_pulse got=%0d exp=1", errs); end
    checks++; if (other != 0) begin failures++; $display("FAIL unknown_code got=%0d exp=0", other); end
    checks++; if (txlow != 0) begin failures++; $display("FAIL unknown_tx got=%0d low cycles exp=0", txlow); end
  endtask

  task automatic test_random_cmds();
    logic [7:0] cmds[4];
    logic [7:0] b;
    logic [6:0] exp;
    logic       experr;
    int first, cnt, other, errs, txlow;
    cmds[0] = 8'h49; cmds[1] = 8'h41; cmds[2] = 8'h45; cmds[3] = 8'h4C;
    for (int n = 0; n < 8; n++) begin
      if ($urandom_range(0, 4) < 4) b = cmds[$urandom_range(0, 3)];
      else begin
        do b = 8'($urandom_range(0, 255));
        while (b == 8'h49 || b == 8'h41 || b == 8'h45 || b == 8'h4C || b == 8'h53);
      end
      ref_decode(b, exp, experr);
      observe_cmd(b, 1'b1, exp, first, cnt, other, errs, txlow);
      checks++; if (other != 0) begin failures++; $display("FAIL rand_cmd_other[%0d] byte=%02h got=%0d exp=0", n, b, other); end
      checks++; if (errs != int'(experr)) begin failures++; $display("FAIL rand_cmd_err[%0d] byte=%02h got=%0d exp=%0d", n, b, errs, experr); end
      if (!experr) begin
        checks++; if (cnt != HOLD) begin failures++; $display("FAIL rand_cmd_hold[%0d] byte=%02h got=%0d exp=%0d", n, b, cnt, HOLD); end
        checks++; if (first < 10 || first > 12) begin failures++; $display("FAIL rand_cmd_latency[%0d] got=%0d exp=10..12", n, first); end
      end
      repeat (4) @(negedge clk);
    end
  endtask

  task automatic test_status_change();
    int lat;
    sc_base = tx_bytes.size();
    @(negedge clk);
    outWIFI = 1'b1; outWIFI2 = 1'b0;
    lat = -1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (tx === 1'b0 && lat < 0) lat = k;
    end
    checks++; if (lat < 1 || lat > 4) begin failures++; $display("FAIL status_latency got=%0d exp=1..4", lat); end
    repeat (30) @(negedge clk);
    outWIFI = 1'b0; outWIFI2 = 1'b1;
    repeat (20) @(negedge clk);
    outWIFI = 1'b0; outWIFI2 = 1'b0;
    for (int k = 0; k < 300 && tx_bytes.size() <= sc_base; k++) @(negedge clk);
    checks++;
    if (tx_bytes.size() <= sc_base) begin
      failures++; $display("FAIL status_frame got=timeout exp=%02h", ref_report(2));
    end else if (tx_bytes[sc_base] !== ref_report(2) || tx_ok[sc_base] !== 1'b1) begin
      failures++; $display("FAIL status_frame got=%02h framing=%b exp=%02h", tx_bytes[sc_base], tx_ok[sc_base], ref_report(2));
    end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 400 && tx_bytes.size() <= sc_base + 1; k++) @(negedge clk);
    checks++;
    if (tx_bytes.size() <= sc_base + 1) begin
      failures++; $display("FAIL b2b_frame got=timeout exp=%02h", ref_report(0));
    end else begin
      if (tx_bytes[sc_base + 1] !== ref_report(0) || tx_ok[sc_base + 1] !== 1'b1) begin
        failures++; $display("FAIL b2b_frame got=%02h framing=%b exp=%02h", tx_bytes[sc_base + 1], tx_ok[sc_base + 1], ref_report(0));
      end
      checks++;
      if (tx_t[sc_base + 1] - tx_t[sc_base] != 160) begin
        failures++; $display("FAIL b2b_gap got=%0d exp=160", tx_t[sc_base + 1] - tx_t[sc_base]);
      end
    end
    repeat (200) @(negedge clk);
    checks++; if (tx_bytes.size() != sc_base + 2) begin failures++; $display("FAIL b2b_count got=%0d exp=%0d", tx_bytes.size() - sc_base, 2); end
  endtask

  task automatic test_query_reset();
    int n0, found, txlow;
    n0 = tx_bytes.size();
    send_frame(8'h53, 1'b1);
    for (int k = 0; k < 300 && tx_bytes.size() <= n0; k++) @(negedge clk);
    checks++;
    if (tx_bytes.size() <= n0) begin
      failures++; $display("FAIL query_frame got=timeout exp=%02h", ref_report(0));
    end else if (tx_bytes[n0] !== ref_report(0) || tx_ok[n0] !== 1'b1) begin
      failures++; $display("FAIL query_frame got=%02h framing=%b exp=%02h", tx_bytes[n0], tx_ok[n0], ref_report(0));
    end
    checks++; if ({inWIFI, inWIFI2} !== 7'd0) begin failures++; $display("FAIL query_code got=%b exp=0000000", {inWIFI, inWIFI2}); end
    send_frame(8'h53, 1'b1);
    found = 0;
    for (int k = 0; k < 40 && found == 0; k++) begin
      @(negedge clk);
      if (tx === 1'b0) found = 1;
    end
    checks++; if (found == 0) begin failures++; $display("FAIL query2_start got=timeout exp=start bit"); end
    repeat (60) @(negedge clk);
    reset = 1'b0;
    #1;
    checks++; if (tx !== 1'b1) begin failures++; $display("FAIL midreset_tx got=%b exp=1", tx); end
    checks++; if ({inWIFI, inWIFI2} !== 7'd0) begin failures++; $display("FAIL midreset_code got=%b exp=0000000", {inWIFI, inWIFI2}); end
    checks++; if (link_err !== 1'b0) begin failures++; $display("FAIL midreset_link_err got=%b exp=0", link_err); end
    txlow = 0;
    repeat (20) begin
      @(negedge clk);
      if (tx !== 1'b1) txlow++;
    end
    checks++; if (txlow != 0) begin failures++; $display("FAIL midreset_hold_tx got=%0d low cycles exp=0", txlow); end
    reset = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_arm();
    test_framing_err();
    test_unknown();
    test_random_cmds();
    test_status_change();
    test_back_to_back();
    test_query_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
